// File: rtl/rf_pkg.sv
// Shared defaults and address typing for the RISC-V register file with scoreboard.
package rf_pkg;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Write-pending scoreboard: busy vector, incremental pending counter and issue gating.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             iss_ready,
  output logic [AW:0]      pend_cnt
);

  logic wb_hit;
  logic iss_take;
  logic inc;
  logic dec;

  always_comb begin
    iss_ready = !flush && ((iss_rd == AW'(ZERO_REG)) || !busy[iss_rd] ||
                           (we && (wa == iss_rd)));
    wb_hit    = we && (wa != AW'(ZERO_REG)) && busy[wa];
    iss_take  = iss_valid && iss_ready && (iss_rd != AW'(ZERO_REG));
    inc       = iss_take && !busy[iss_rd];
    // A writeback to the register being re-issued leaves it busy, so no decrement.
    dec       = wb_hit && !(iss_take && (wa == iss_rd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else if (flush) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      // Set after clear so a same-cycle re-issue keeps the bit.
      if (wb_hit)   busy[wa]     <= 1'b0;
      if (iss_take) busy[iss_rd] <= 1'b1;
      if (inc && !dec)      pend_cnt <= pend_cnt + (AW+1)'(1);
      else if (dec && !inc) pend_cnt <= pend_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rf_riscv_sb.sv
// RISC-V integer register file with write-pending scoreboard; x0 reads zero and is never busy.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module rf_riscv_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            flush,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_en;

  assign wr_en = we && (wa != AW'(ZERO_REG));

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wa        (wa),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .busy      (busy),
    .iss_ready (iss_ready),
    .pend_cnt  (pend_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    rd2   = '0;
    busy2 = 1'b0;
    if (ra1 != AW'(ZERO_REG)) begin
      rd1   = mem[ra1];
      busy1 = busy[ra1];
    end
    if (ra2 != AW'(ZERO_REG)) begin
      rd2   = mem[ra2];
      busy2 = busy[ra2];
    end
`ifdef RF_BYPASS_EN
    if (wr_en && (ra1 == wa)) begin
      rd1   = wd;
      busy1 = 1'b0;
    end
    if (wr_en && (ra2 == wa)) begin
      rd2   = wd;
      busy2 = 1'b0;
    end
`endif
  end

endmodule
